// File: rtl/ram512_loader_if.sv
// Write-side bus between the loader and its neighbours: the incoming word stream
// and the registered RAM512 write port.
interface ram512_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;

  // master is the stream source that also watches the RAM port; slave is the loader
  modport master (
    output s_valid, s_data,
    input  s_ready, ram_address, ram_in, ram_load
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, ram_address, ram_in, ram_load
  );
endinterface

// File: rtl/ram512_loader.sv
// Write sequencer for RAM512: zero-fills the whole memory or streams words
// into consecutive (wrapping) addresses from a base address.
module ram512_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_clear,
  input  logic              start_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  ram512_loader_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FLUSH, DONE} state_t;

  localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [ADDR_W-1:0] pointer, pointer_n;
  logic [ADDR_W:0]   remaining, remaining_n;
  logic [ADDR_W:0]   written, written_n;
  logic [ADDR_W-1:0] ram_address_q, ram_address_n;
  logic [DATA_W-1:0] ram_in_q, ram_in_n;
  logic              ram_load_q, ram_load_n;
  logic              ready;
  logic              handshake;

  assign ready     = (state == LOAD) && (remaining != '0);
  assign handshake = bus.s_valid && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pointer       <= '0;
      remaining     <= '0;
      written       <= '0;
      ram_address_q <= '0;
      ram_in_q      <= '0;
      ram_load_q    <= 1'b0;
    end else begin
      state         <= state_n;
      pointer       <= pointer_n;
      remaining     <= remaining_n;
      written       <= written_n;
      ram_address_q <= ram_address_n;
      ram_in_q      <= ram_in_n;
      ram_load_q    <= ram_load_n;
    end
  end

  // Every write is registered one cycle ahead of the RAM, so leaving CLEAR/LOAD
  // goes through FLUSH while the final ram_load pulse is still on the pins.
  always_comb begin
    state_n       = state;
    pointer_n     = pointer;
    remaining_n   = remaining;
    written_n     = written;
    ram_address_n = ram_address_q;
    ram_in_n      = ram_in_q;
    ram_load_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start_clear) begin
          state_n     = CLEAR;
          pointer_n   = '0;
          remaining_n = FULL;
          written_n   = '0;
        end else if (start_load) begin
          pointer_n   = base_addr;
          remaining_n = (count > FULL) ? FULL : count;
          written_n   = '0;
          state_n     = (count == '0) ? DONE : LOAD;
        end
      end
      CLEAR: begin
        ram_load_n    = 1'b1;
        ram_address_n = pointer;
        ram_in_n      = '0;
        pointer_n     = pointer + PTR_ONE;
        remaining_n   = remaining - CNT_ONE;
        if (written != FULL) written_n = written + CNT_ONE;
        if (remaining == CNT_ONE) state_n = FLUSH;
      end
      LOAD: begin
        if (handshake) begin
          ram_load_n    = 1'b1;
          ram_address_n = pointer;
          ram_in_n      = bus.s_data;
          pointer_n     = pointer + PTR_ONE;
          remaining_n   = remaining - CNT_ONE;
          if (written != FULL) written_n = written + CNT_ONE;
          if (remaining == CNT_ONE) state_n = FLUSH;
        end
      end
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.s_ready     = ready;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_in      = ram_in_q;
  assign bus.ram_load    = ram_load_q;
  assign busy            = (state == CLEAR) || (state == LOAD) || (state == FLUSH);
  assign done            = (state == DONE);
  assign words_written   = written;

endmodule

// File: tb/tb_ram512_loader.sv
// Directed bench for ram512_loader: table of load scenarios plus hand-written
// clear, collision and reset-abort sequences against a behavioural RAM512.
module tb_ram512_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_clear;
  logic       start_load;
  logic [8:0] base_addr;
  logic [9:0] count;
  logic       busy;
  logic       done;
  logic [9:0] words_written;

  int n_pass;
  int n_total;

  always #5 clk = ~clk;

  ram512_loader_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  ram512_loader #(.ADDR_W(9), .DATA_W(16), .DEPTH(512)) dut (
    .clk(clk),
    .reset(reset),
    .start_clear(start_clear),
    .start_load(start_load),
    .base_addr(base_addr),
    .count(count),
    .bus(bus),
    .busy(busy),
    .done(done),
    .words_written(words_written)
  );

  // Behavioural RAM512: commits on the edge that ends a ram_load cycle
  logic [15:0] ram [512];
  always @(posedge clk) begin
    if (bus.ram_load) ram[bus.ram_address] <= bus.ram_in;
  end

  typedef struct {
    logic [8:0]  base;
    logic [9:0]  cnt;
    logic        toggle;
    logic [15:0] seed;
    logic [15:0] step;
    int          exp_writes;
    int          exp_done_t;
    logic [8:0]  exp_last_addr;
    logic [15:0] exp_last_data;
    logic [8:0]  chk_addr;
    logic [15:0] chk_data;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
  endtask

  // Runs one load scenario; t counts edges after the start edge
  task automatic applyStimulus(input int idx);
    vec_t        v;
    int          hs, pulses, done_t, bad_addr, bad_data, ready_late, ready_missing, busy_low;
    logic        drive_valid, hs_now;
    logic [15:0] word;
    logic [8:0]  exp_addr;
    v = vecs[idx];
    base_addr   = v.base;
    count       = v.cnt;
    start_load  = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    start_load = 1'b0;
    checkOutput($sformatf("vec%0d words_written at start", idx), int'(words_written), 0);
    hs = 0; pulses = 0; done_t = -1; bad_addr = 0; bad_data = 0;
    ready_late = 0; ready_missing = 0; busy_low = 0;
    for (int t = 0; t < 1200; t++) begin
      if (bus.ram_load) begin
        exp_addr = v.base + 9'(pulses);
        word     = v.seed + 16'(pulses) * v.step;
        if (bus.ram_address != exp_addr) bad_addr++;
        if (bus.ram_in != word) bad_data++;
        pulses++;
      end
      if (done) begin
        done_t = t;
        break;
      end
      if (!busy) busy_low++;
      if (bus.s_ready && hs >= v.exp_writes) ready_late++;
      if (!bus.s_ready && hs < v.exp_writes) ready_missing++;
      drive_valid = v.toggle ? ((t % 2) == 0) : 1'b1;
      bus.s_valid = drive_valid;
      bus.s_data  = v.seed + 16'(hs) * v.step;
      hs_now      = drive_valid && bus.s_ready;
      tick();
      if (hs_now) hs++;
    end
    bus.s_valid = 1'b0;
    checkOutput($sformatf("vec%0d done cycle", idx), done_t, v.exp_done_t);
    checkOutput($sformatf("vec%0d ram_load pulses", idx), pulses, v.exp_writes);
    checkOutput($sformatf("vec%0d words_written", idx), int'(words_written), v.exp_writes);
    checkOutput($sformatf("vec%0d address errors", idx), bad_addr, 0);
    checkOutput($sformatf("vec%0d data errors", idx), bad_data, 0);
    checkOutput($sformatf("vec%0d s_ready after last", idx), ready_late, 0);
    checkOutput($sformatf("vec%0d s_ready missing", idx), ready_missing, 0);
    checkOutput($sformatf("vec%0d busy low while active", idx), busy_low, 0);
    checkOutput($sformatf("vec%0d busy in done cycle", idx), int'(busy), 0);
    tick();
    if (v.exp_writes > 0)
      checkOutput($sformatf("vec%0d ram last word", idx),
                  int'(ram[v.exp_last_addr]), int'(v.exp_last_data));
    checkOutput($sformatf("vec%0d ram readback", idx), int'(ram[v.chk_addr]), int'(v.chk_data));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses, done_t, first_t, bad_addr, bad_data, ready_seen, idle_bad, nonzero;
    n_pass = 0;
    n_total = 0;
    vecs[0] = '{base: 9'd10,  cnt: 10'd4,   toggle: 1'b0, seed: 16'hAAAA, step: 16'h1111,
                exp_writes: 4,   exp_done_t: 5,   exp_last_addr: 9'd13,  exp_last_data: 16'hDDDD,
                chk_addr: 9'd10, chk_data: 16'hAAAA};
    vecs[1] = '{base: 9'd510, cnt: 10'd4,   toggle: 1'b1, seed: 16'hAAAA, step: 16'h1111,
                exp_writes: 4,   exp_done_t: 8,   exp_last_addr: 9'd1,   exp_last_data: 16'hDDDD,
                chk_addr: 9'd0,  chk_data: 16'hCCCC};
    vecs[2] = '{base: 9'd7,   cnt: 10'd0,   toggle: 1'b0, seed: 16'h0000, step: 16'h0000,
                exp_writes: 0,   exp_done_t: 0,   exp_last_addr: 9'd0,   exp_last_data: 16'h0000,
                chk_addr: 9'd10, chk_data: 16'hAAAA};
    vecs[3] = '{base: 9'd511, cnt: 10'd1,   toggle: 1'b0, seed: 16'h5A5A, step: 16'h0000,
                exp_writes: 1,   exp_done_t: 2,   exp_last_addr: 9'd511, exp_last_data: 16'h5A5A,
                chk_addr: 9'd1,  chk_data: 16'hDDDD};
    vecs[4] = '{base: 9'd0,   cnt: 10'd700, toggle: 1'b0, seed: 16'h0100, step: 16'h0003,
                exp_writes: 512, exp_done_t: 513, exp_last_addr: 9'd511, exp_last_data: 16'h06FD,
                chk_addr: 9'd0,  chk_data: 16'h0100};

    reset = 1'b1;
    start_clear = 1'b0;
    start_load = 1'b0;
    base_addr = '0;
    count = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ram_address", int'(bus.ram_address), 0);
    checkOutput("reset ram_in", int'(bus.ram_in), 0);
    checkOutput("reset ram_load", int'(bus.ram_load), 0);
    checkOutput("reset s_ready", int'(bus.s_ready), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset words_written", int'(words_written), 0);
    reset = 1'b0;
    tick();

    // Clear with a simultaneous load request, plus a load request while busy
    start_clear = 1'b1;
    start_load = 1'b1;
    base_addr = 9'd100;
    count = 10'd3;
    tick();
    start_clear = 1'b0;
    start_load = 1'b0;
    pulses = 0; done_t = -1; first_t = -1; bad_addr = 0; bad_data = 0; ready_seen = 0;
    for (int t = 0; t < 600; t++) begin
      if (bus.ram_load) begin
        if (first_t < 0) first_t = t;
        if (bus.ram_address != 9'(pulses)) bad_addr++;
        if (bus.ram_in != 16'h0000) bad_data++;
        pulses++;
      end
      if (bus.s_ready) ready_seen++;
      if (done) begin
        done_t = t;
        break;
      end
      start_load = (t == 10);
      tick();
    end
    checkOutput("clear first pulse cycle", first_t, 1);
    checkOutput("clear pulses", pulses, 512);
    checkOutput("clear done cycle", done_t, 513);
    checkOutput("clear words_written", int'(words_written), 512);
    checkOutput("clear address errors", bad_addr, 0);
    checkOutput("clear data errors", bad_data, 0);
    checkOutput("clear s_ready seen", ready_seen, 0);

    // A start in the DONE cycle must be ignored
    start_load = 1'b1;
    base_addr = 9'd0;
    count = 10'd5;
    tick();
    start_load = 1'b0;
    idle_bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (busy || bus.ram_load || bus.s_ready || done) idle_bad++;
      tick();
    end
    checkOutput("idle after clear activity", idle_bad, 0);
    checkOutput("words_written held after clear", int'(words_written), 512);
    nonzero = 0;
    for (int a = 0; a < 512; a++) if (ram[a] != 16'h0000) nonzero++;
    checkOutput("clear readback nonzero words", nonzero, 0);

    // Reset in the middle of a 5-word load after two words are written
    base_addr = 9'd200;
    count = 10'd5;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = 16'h1000;
    tick();
    checkOutput("abort first write address", int'(bus.ram_address), 200);
    bus.s_data = 16'h1001;
    tick();
    bus.s_valid = 1'b0;
    tick();
    checkOutput("abort words_written before reset", int'(words_written), 2);
    checkOutput("abort busy before reset", int'(busy), 1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("abort ram_address", int'(bus.ram_address), 0);
    checkOutput("abort ram_in", int'(bus.ram_in), 0);
    checkOutput("abort ram_load", int'(bus.ram_load), 0);
    checkOutput("abort s_ready", int'(bus.s_ready), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort words_written", int'(words_written), 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("abort no done after release", int'(done), 0);
    checkOutput("abort ram[200]", int'(ram[200]), 16'h1000);
    checkOutput("abort ram[201]", int'(ram[201]), 16'h1001);
    checkOutput("abort ram[202]", int'(ram[202]), 0);

    for (int i = 0; i < 5; i++) applyStimulus(i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
